// File: rtl/axi_iops_pkg.sv
// ----------------------------------------------------------------------------
// axi_iops_pkg
// Shared definitions for the AXI read IOPS sweep block: default parameter
// values, counter widths, the sweep state encoding and a small helper that
// normalises the per-step window length.
// ----------------------------------------------------------------------------
package axi_iops_pkg;

    localparam int LEN_SIZE_DEF = 4;    // AXI burst-length field width
    localparam int OUT_BITS_DEF = 16;   // outstanding-burst counter width
    localparam int CNT_W        = 32;   // result counters and window width
    localparam int ARSIZE_W     = 3;    // AXI burst-size field width

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } sweep_state_e;

    // A zero-length window would never let RUN finish cleanly, so it is
    // treated as a single-cycle window.
    function automatic logic [CNT_W-1:0] window_norm(input logic [CNT_W-1:0] w);
        window_norm = (w == {CNT_W{1'b0}}) ? {{(CNT_W-1){1'b0}}, 1'b1} : w;
    endfunction

endpackage

// File: rtl/axi_iops_sweep_if.sv
// ----------------------------------------------------------------------------
// axi_iops_sweep_if
// Bundles the passive AR/R channel taps and the per-step result handshake of
// axi_iops_sweep.
//   mon_arvalid/mon_arready           : AR channel handshake tap
//   mon_rvalid/mon_rready/mon_rlast   : R channel handshake tap
//   res_valid/res_ready               : result handshake
//   res_arlen/res_count/res_cycles    : result payload
// Modports: slave = the sweep block, master = traffic source / result sink.
// ----------------------------------------------------------------------------
interface axi_iops_sweep_if #(
    parameter int LEN_SIZE = axi_iops_pkg::LEN_SIZE_DEF
);
    logic                            mon_arvalid;
    logic                            mon_arready;
    logic                            mon_rvalid;
    logic                            mon_rready;
    logic                            mon_rlast;
    logic                            res_valid;
    logic                            res_ready;
    logic [LEN_SIZE-1:0]             res_arlen;
    logic [axi_iops_pkg::CNT_W-1:0]  res_count;
    logic [axi_iops_pkg::CNT_W-1:0]  res_cycles;

    modport slave (
        input  mon_arvalid, mon_arready, mon_rvalid, mon_rready, mon_rlast,
        input  res_ready,
        output res_valid, res_arlen, res_count, res_cycles
    );

    modport master (
        output mon_arvalid, mon_arready, mon_rvalid, mon_rready, mon_rlast,
        output res_ready,
        input  res_valid, res_arlen, res_count, res_cycles
    );
endinterface

// File: rtl/axi_rd_outstanding.sv
// ----------------------------------------------------------------------------
// axi_rd_outstanding
// Counts AXI read bursts in flight: +1 per AR handshake, -1 per last-beat R
// handshake. Underflow holds at zero and overflow saturates; either raises a
// sticky error that only reset clears.
//   clock, reset (sync, active-high)
//   ar_hs        : AR handshake this cycle
//   r_last_hs    : last-beat R handshake this cycle
//   outstanding  : bursts in flight (registered)
//   err          : sticky underflow/overflow flag (registered)
// ----------------------------------------------------------------------------
module axi_rd_outstanding #(
    parameter int OUT_BITS = axi_iops_pkg::OUT_BITS_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ar_hs,
    input  logic                r_last_hs,
    output logic [OUT_BITS-1:0] outstanding,
    output logic                err
);

    localparam logic [OUT_BITS-1:0] CNT_MAX  = {OUT_BITS{1'b1}};
    localparam logic [OUT_BITS-1:0] CNT_ZERO = {OUT_BITS{1'b0}};

    // In-flight burst counter with clamping and sticky error capture
    always_ff @(posedge clock) begin
        if (reset) begin
            outstanding <= CNT_ZERO;
            err         <= 1'b0;
        end else begin
            case ({ar_hs, r_last_hs})
                2'b10: begin
                    if (outstanding == CNT_MAX) begin
                        err <= 1'b1;
                    end else begin
                        outstanding <= outstanding + OUT_BITS'(1'b1);
                    end
                end
                2'b01: begin
                    if (outstanding == CNT_ZERO) begin
                        err <= 1'b1;
                    end else begin
                        outstanding <= outstanding - OUT_BITS'(1'b1);
                    end
                end
                default: begin
                    // idle or simultaneous issue and retire: count unchanged
                    outstanding <= outstanding;
                end
            endcase
        end
    end

endmodule

// File: rtl/axi_iops_sweep.sv
// ----------------------------------------------------------------------------
// axi_iops_sweep
// Sweeps the AXI read burst length from 0 to cfg_len_max. For each length it
// lets the traffic generator run for a window, pauses it, waits for all reads
// to retire, and reports how many bursts completed and how many cycles the
// step took.
//   clock, reset (sync, active-high)
//   start, cfg_arsize, cfg_len_max, cfg_window : sweep configuration
//   abort                                      : end the sweep early
//   bus (slave)   : AR/R taps and result handshake
//   debug_arsize, debug_arlen, debug_pause     : traffic generator control
//   busy, done (pulse), err (sticky)           : status
// ----------------------------------------------------------------------------
module axi_iops_sweep
    import axi_iops_pkg::*;
#(
    parameter int LEN_SIZE = LEN_SIZE_DEF,
    parameter int OUT_BITS = OUT_BITS_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ARSIZE_W-1:0]  cfg_arsize,
    input  logic [LEN_SIZE-1:0]  cfg_len_max,
    input  logic [CNT_W-1:0]     cfg_window,
    input  logic                 abort,
    axi_iops_sweep_if.slave      bus,
    output logic [ARSIZE_W-1:0]  debug_arsize,
    output logic [LEN_SIZE-1:0]  debug_arlen,
    output logic                 debug_pause,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    sweep_state_e          state_r;
    logic [LEN_SIZE-1:0]   step_r;
    logic [LEN_SIZE-1:0]   len_max_r;
    logic [CNT_W-1:0]      window_r;
    logic [CNT_W-1:0]      win_cnt_r;
    logic                  aborted_r;
    logic                  res_valid_r;
    logic [LEN_SIZE-1:0]   res_arlen_r;
    logic [CNT_W-1:0]      res_count_r;
    logic [CNT_W-1:0]      res_cycles_r;

    logic                  ar_hs_s;
    logic                  rl_hs_s;
    logic                  drain_clear_s;
    logic [OUT_BITS-1:0]   outstanding_s;

    assign ar_hs_s       = bus.mon_arvalid & bus.mon_arready;
    assign rl_hs_s       = bus.mon_rvalid & bus.mon_rready & bus.mon_rlast;
    // An AR still waiting for ready would be lost if we reported now.
    assign drain_clear_s = ~bus.mon_arvalid & (outstanding_s == {OUT_BITS{1'b0}});

    assign bus.res_valid  = res_valid_r;
    assign bus.res_arlen  = res_arlen_r;
    assign bus.res_count  = res_count_r;
    assign bus.res_cycles = res_cycles_r;

    axi_rd_outstanding #(
        .OUT_BITS    (OUT_BITS)
    ) u_outstanding (
        .clock       (clock),
        .reset       (reset),
        .ar_hs       (ar_hs_s),
        .r_last_hs   (rl_hs_s),
        .outstanding (outstanding_s),
        .err         (err)
    );

    // Sweep sequencer: state, step bookkeeping, result counters and outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            step_r       <= {LEN_SIZE{1'b0}};
            len_max_r    <= {LEN_SIZE{1'b0}};
            window_r     <= {{(CNT_W-1){1'b0}}, 1'b1};
            win_cnt_r    <= {CNT_W{1'b0}};
            aborted_r    <= 1'b0;
            res_valid_r  <= 1'b0;
            res_arlen_r  <= {LEN_SIZE{1'b0}};
            res_count_r  <= {CNT_W{1'b0}};
            res_cycles_r <= {CNT_W{1'b0}};
            debug_arsize <= {ARSIZE_W{1'b0}};
            debug_arlen  <= {LEN_SIZE{1'b0}};
            debug_pause  <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;

            // Step measurement runs through RUN and DRAIN; wraps naturally.
            if ((state_r == ST_RUN) || (state_r == ST_DRAIN)) begin
                res_cycles_r <= res_cycles_r + 32'd1;
                if (rl_hs_s) begin
                    res_count_r <= res_count_r + 32'd1;
                end
            end

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        len_max_r    <= cfg_len_max;
                        window_r     <= window_norm(cfg_window);
                        step_r       <= {LEN_SIZE{1'b0}};
                        debug_arlen  <= {LEN_SIZE{1'b0}};
                        debug_arsize <= cfg_arsize;
                        debug_pause  <= 1'b0;
                        busy         <= 1'b1;
                        win_cnt_r    <= 32'd1;
                        aborted_r    <= 1'b0;
                        res_count_r  <= {CNT_W{1'b0}};
                        res_cycles_r <= {CNT_W{1'b0}};
                        state_r      <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    // win_cnt_r numbers the current RUN cycle starting at 1
                    if (abort || (win_cnt_r == window_r)) begin
                        aborted_r   <= abort;
                        debug_pause <= 1'b1;
                        state_r     <= ST_DRAIN;
                    end else begin
                        win_cnt_r <= win_cnt_r + 32'd1;
                    end
                end

                ST_DRAIN: begin
                    if (drain_clear_s) begin
                        if (aborted_r || abort) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= ST_IDLE;
                        end else begin
                            res_valid_r <= 1'b1;
                            res_arlen_r <= step_r;
                            state_r     <= ST_REPORT;
                        end
                    end else if (abort) begin
                        aborted_r <= 1'b1;
                    end
                end

                ST_REPORT: begin
                    if (bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        if (aborted_r || abort || (step_r == len_max_r)) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= ST_IDLE;
                        end else begin
                            step_r       <= step_r + LEN_SIZE'(1'b1);
                            debug_arlen  <= step_r + LEN_SIZE'(1'b1);
                            debug_pause  <= 1'b0;
                            win_cnt_r    <= 32'd1;
                            aborted_r    <= 1'b0;
                            res_count_r  <= {CNT_W{1'b0}};
                            res_cycles_r <= {CNT_W{1'b0}};
                            state_r      <= ST_RUN;
                        end
                    end else if (abort) begin
                        // honoured once the pending result is accepted
                        aborted_r <= 1'b1;
                    end
                end

                default: begin
                    res_valid_r <= 1'b0;
                    debug_pause <= 1'b1;
                    busy        <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/axi_iops_sweep.md
AXI_IOPS_SWEEP -- requirements
Module: axi_iops_sweep

Interface
REQ-001 SHALL have parameter LEN_SIZE, default 4, meaning AXI burst-length field width.
REQ-002 SHALL have parameter OUT_BITS, default 16, meaning outstanding-burst counter width.
REQ-003 SHALL have port clock  in  1  system clock; reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have start  in  1  pulse that begins a sweep; cfg_arsize  in  3  burst size, sampled at start.
REQ-005 SHALL have cfg_len_max  in  LEN_SIZE  last arlen of the sweep, sampled at start; cfg_window  in  32  run cycles per step, sampled at start.
REQ-006 SHALL have abort  in  1  request to end the sweep early.
REQ-007 SHALL have mon_arvalid, mon_arready, mon_rvalid, mon_rready, mon_rlast  in  1 each; these are passive taps on the traffic generator's AR and R channels.
REQ-008 SHALL have debug_arsize  out  3, debug_arlen  out  LEN_SIZE, debug_pause  out  1; these drive the traffic generator configuration.
REQ-009 SHALL have res_valid  out  1, res_ready  in  1, res_arlen  out  LEN_SIZE, res_count  out  32, res_cycles  out  32; these form the per-step result handshake.
REQ-010 SHALL have busy  out  1, done  out  1 (one-cycle pulse), err  out  1 (sticky).

Function
REQ-011 SHALL implement states IDLE, RUN, DRAIN, REPORT; all outputs SHALL be registered.
REQ-012 In IDLE, start=1 SHALL latch the cfg_* inputs, set step=0 and debug_arlen=0, set debug_arsize=cfg_arsize and debug_pause=0, and enter RUN on the next cycle; cfg_window=0 SHALL be treated as 1.
REQ-013 start SHALL be ignored outside IDLE.
REQ-014 RUN SHALL last exactly W cycles, where W is the latched window, with debug_pause=0; RUN SHALL then enter DRAIN.
REQ-015 DRAIN SHALL hold debug_pause=1 until mon_arvalid=0 and outstanding=0 are both true in the same cycle, then enter REPORT.
REQ-016 outstanding SHALL increment on each AR handshake (mon_arvalid&mon_arready) and decrement on each last R handshake (mon_rvalid&mon_rready&mon_rlast); both in one cycle SHALL leave it unchanged; it SHALL be tracked in every state.
REQ-017 A decrement at outstanding=0 SHALL hold the count at 0 and set err; an increment at 2^OUT_BITS-1 SHALL saturate and set err.
REQ-018 res_count SHALL count last R handshakes during RUN and DRAIN of the current step; res_cycles SHALL count cycles spent in RUN plus DRAIN; both SHALL clear on entry to RUN and wrap modulo 2^32.
REQ-019 REPORT SHALL assert res_valid with res_arlen=step and hold all res_* stable until res_ready=1.
REQ-020 On res_ready=1 in REPORT: if step=len_max, the block SHALL go to IDLE and pulse done; otherwise it SHALL set step+1 and debug_arlen=step+1, deassert debug_pause, and enter RUN.
REQ-021 abort in RUN SHALL enter DRAIN immediately; a drain reached via abort SHALL go to IDLE without REPORT and SHALL pulse done; abort in DRAIN SHALL mark the drain aborted; abort in REPORT SHALL take effect after the handshake (IDLE, done pulse); abort in IDLE SHALL have no effect.
REQ-022 busy SHALL be 1 in every state except IDLE; debug_pause SHALL be 1 in every state except RUN.
REQ-023 step arithmetic SHALL be LEN_SIZE wide; cfg_len_max=2^LEN_SIZE-1 SHALL end after that step without wrapping.

Reset
REQ-024 reset SHALL force IDLE, debug_pause=1, debug_arsize=0, debug_arlen=0, res_valid=0, res_arlen=0, res_count=0, res_cycles=0, busy=0, done=0, err=0, outstanding=0.
REQ-025 reset mid-sweep SHALL discard all progress; no result or done pulse SHALL be emitted.

Structure
REQ-026 The state enum, the default LEN_SIZE and OUT_BITS, and the counter widths SHALL reside in shared package axi_iops_pkg.
REQ-027 Outstanding tracking (REQ-016/017) SHALL be a sub-module named axi_rd_outstanding.

Verification
REQ-028 Scenario: cfg_len_max=2, window=100, responder with 1 outstanding and 10-cycle latency, res_ready=1 -> three results with arlen 0,1,2, each res_cycles>=100, then done pulse, busy=0.
REQ-029 Scenario: mon_arready low for 50 cycles at the window end -> DRAIN holds until the AR handshake and its rlast; res_count includes that burst.
REQ-030 Scenario: AR handshake and rlast in the same cycle with outstanding=3 -> outstanding stays 3, err=0.
REQ-031 Scenario: rlast at outstanding=0 -> outstanding=0, err=1 and sticky until reset.
REQ-032 Scenario: abort 20 cycles into step 1 -> pause, drain, IDLE, done pulse, no res_valid for step 1.
REQ-033 Scenario: res_ready held 0 for 30 cycles, then reset asserted -> res_valid=0 and all outputs at REQ-024 values next cycle.
